// File: rtl/taxi_ride_fsm_pkg.sv
// Shared definitions for the taxi ride controller: ride-state encodings,
// button-event bundle and the silence-timer width.
package taxi_ride_fsm_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MOVE = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b11;

    localparam int SIL_W = 8;

    typedef struct packed {
        logic stop;
        logic pause;
        logic start;
    } btn_ev_t;

    function automatic logic [SIL_W-1:0] sil_inc(input logic [SIL_W-1:0] v);
        return (v == '1) ? v : v + SIL_W'(1);
    endfunction

endpackage

// File: rtl/taxi_ride_fsm_btn_edge.sv
// Single-bit rising-edge detector; the previous-level register clears on reset,
// so a level held through reset reports an edge right after release.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/taxi_ride_fsm.sv
// Ride-control FSM (IDLE/MOVE/WAIT) with saturating ride statistics.
// Optional automatic WAIT on wheel silence is enabled by defining TAXI_AUTO_WAIT_EN.
module taxi_ride_fsm
    import taxi_ride_fsm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             btn_stop,
    input  logic             wheel_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] move_sec,
    output logic [CNT_W-1:0] wait_sec,
    output logic [CNT_W-1:0] dist_units,
    output logic             ride_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    btn_ev_t    ev;

    assign btn_level = {btn_stop, btn_pause, btn_start};
    assign ev        = btn_ev_t'(btn_rise);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            btn_edge u_edge (
                .clk   (clk),
                .rst_n (rst_n),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] move_reg, move_next;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0] dist_reg, dist_next;
    logic             done_reg, done_next;

`ifdef TAXI_AUTO_WAIT_EN
    localparam logic [SIL_W-1:0] TIMEOUT_V = SIL_W'(TIMEOUT);

    logic [SIL_W-1:0] sil_reg, sil_next;
`endif

    always_comb begin
        state_next = state_reg;
        move_next  = move_reg;
        wait_next  = wait_reg;
        dist_next  = dist_reg;
        done_next  = 1'b0;
`ifdef TAXI_AUTO_WAIT_EN
        sil_next   = sil_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ev.start) begin
                    state_next = ST_MOVE;
                    move_next  = '0;
                    wait_next  = '0;
                    dist_next  = '0;
`ifdef TAXI_AUTO_WAIT_EN
                    sil_next   = '0;
`endif
                end
            end
            ST_MOVE: begin
                if (tick_1hz)    move_next = cnt_inc(move_reg);
                if (wheel_pulse) dist_next = cnt_inc(dist_reg);
`ifdef TAXI_AUTO_WAIT_EN
                // A wheel pulse beats a coincident tick: timer clears, no timeout.
                if (wheel_pulse)   sil_next = '0;
                else if (tick_1hz) sil_next = sil_inc(sil_reg);
`endif
                if (ev.stop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (ev.pause) begin
                    state_next = ST_WAIT;
                end
`ifdef TAXI_AUTO_WAIT_EN
                else if (!wheel_pulse && tick_1hz && sil_inc(sil_reg) >= TIMEOUT_V) begin
                    state_next = ST_WAIT;
                end
`endif
            end
            ST_WAIT: begin
                if (tick_1hz) wait_next = cnt_inc(wait_reg);
                if (ev.stop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (ev.start || ev.pause) begin
                    state_next = ST_MOVE;
`ifdef TAXI_AUTO_WAIT_EN
                    sil_next   = '0;
`endif
                end
`ifdef TAXI_AUTO_WAIT_EN
                else if (wheel_pulse) begin
                    state_next = ST_MOVE;
                    dist_next  = cnt_inc(dist_reg);
                    sil_next   = '0;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            move_reg  <= '0;
            wait_reg  <= '0;
            dist_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            move_reg  <= move_next;
            wait_reg  <= wait_next;
            dist_reg  <= dist_next;
            done_reg  <= done_next;
        end
    end

`ifdef TAXI_AUTO_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sil_reg <= '0;
        end else begin
            sil_reg <= sil_next;
        end
    end
`endif

    assign state      = state_reg;
    assign move_sec   = move_reg;
    assign wait_sec   = wait_reg;
    assign dist_units = dist_reg;
    assign ride_done  = done_reg;

endmodule

// File: tb/tb_taxi_ride_fsm.sv
// Self-checking bench for taxi_ride_fsm: directed scenarios plus randomized traffic
// checked against a behavioural ride model (auto-wait scenario when TAXI_AUTO_WAIT_EN is defined).
module tb_taxi_ride_fsm;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 5;
    localparam int MAXV    = 65535;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick_1hz = 1'b0;
    logic             btn_start = 1'b0;
    logic             btn_pause = 1'b0;
    logic             btn_stop = 1'b0;
    logic             wheel_pulse = 1'b0;
    logic [1:0]       state;
    logic [CNT_W-1:0] move_sec;
    logic [CNT_W-1:0] wait_sec;
    logic [CNT_W-1:0] dist_units;
    logic             ride_done;

    int total = 0;
    int bad = 0;

    // Behavioural ride model: ride phase as a name, statistics as plain integers.
    typedef enum int {R_IDLE, R_MOVE, R_WAIT} ride_t;
    ride_t m_ride;
    int    m_move, m_wait, m_dist, m_silent;
    bit    m_done, m_ps, m_pp, m_pt;

    taxi_ride_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .btn_stop    (btn_stop),
        .wheel_pulse (wheel_pulse),
        .state       (state),
        .move_sec    (move_sec),
        .wait_sec    (wait_sec),
        .dist_units  (dist_units),
        .ride_done   (ride_done)
    );

    always #5 clk = ~clk;

    function automatic int bump(input int v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    function automatic logic [1:0] ride_code(input ride_t r);
        case (r)
            R_MOVE:  return 2'b01;
            R_WAIT:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_ride = R_IDLE; m_move = 0; m_wait = 0; m_dist = 0; m_silent = 0;
        m_done = 0; m_ps = 0; m_pp = 0; m_pt = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit st, input bit tk, input bit w);
        bit start_ev, pause_ev, stop_ev;
        start_ev = s && !m_ps;
        pause_ev = p && !m_pp;
        stop_ev  = st && !m_pt;
        m_ps = s; m_pp = p; m_pt = st;
        m_done = 0;
        if (m_ride == R_IDLE) begin
            if (start_ev) begin
                m_ride = R_MOVE; m_move = 0; m_wait = 0; m_dist = 0; m_silent = 0;
            end
        end else if (m_ride == R_MOVE) begin
            bit timed_out;
            timed_out = 0;
            if (tk) m_move = bump(m_move);
            if (w)  m_dist = bump(m_dist);
`ifdef TAXI_AUTO_WAIT_EN
            if (w) m_silent = 0;
            else if (tk) begin
                m_silent = m_silent + 1;
                if (m_silent >= TIMEOUT) timed_out = 1;
            end
`endif
            if (stop_ev) begin
                m_ride = R_IDLE; m_done = 1;
            end else if (pause_ev || timed_out) begin
                m_ride = R_WAIT;
            end
        end else begin
            if (tk) m_wait = bump(m_wait);
            if (stop_ev) begin
                m_ride = R_IDLE; m_done = 1;
            end else if (start_ev || pause_ev) begin
                m_ride = R_MOVE; m_silent = 0;
            end
`ifdef TAXI_AUTO_WAIT_EN
            else if (w) begin
                m_ride = R_MOVE; m_silent = 0; m_dist = bump(m_dist);
            end
`endif
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic s, input logic p, input logic st, input logic tk, input logic w);
        btn_start = s; btn_pause = p; btn_stop = st; tick_1hz = tk; wheel_pulse = w;
        model_step(s, p, st, tk, w);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_start = 0; btn_pause = 0; btn_stop = 0; tick_1hz = 0; wheel_pulse = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (state !== 2'b00 || move_sec !== '0 || wait_sec !== '0 || dist_units !== '0 || ride_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: state=%b move=%0d wait=%0d dist=%0d done=%b, want all zero",
                     state, move_sec, wait_sec, dist_units, ride_done);
        end
        $display("reset: state=%b move=%0d wait=%0d dist=%0d", state, move_sec, wait_sec, dist_units);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_count();
        step(1, 0, 0, 0, 0);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL start_to_move: state=%b want 01", state);
        end
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        total++;
        if (move_sec !== 16'd3) begin
            bad++; $display("FAIL move_sec_3: got %0d want 3", move_sec);
        end
        repeat (4) step(0, 0, 0, 0, 1);
        total++;
        if (dist_units !== 16'd4) begin
            bad++; $display("FAIL dist_4: got %0d want 4", dist_units);
        end
        $display("start_count: state=%b move=%0d dist=%0d", state, move_sec, dist_units);
    endtask

    task automatic test_pause_toggle();
        step(0, 1, 0, 0, 0);
        total++;
        if (state !== 2'b11) begin
            bad++; $display("FAIL pause_to_wait: state=%b want 11", state);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        total++;
        if (wait_sec !== 16'd2 || move_sec !== 16'd3) begin
            bad++; $display("FAIL wait_count: wait=%0d move=%0d want wait=2 move=3", wait_sec, move_sec);
        end
`ifndef TAXI_AUTO_WAIT_EN
        step(0, 0, 0, 0, 1);
        total++;
        if (state !== 2'b11 || dist_units !== 16'd4) begin
            bad++; $display("FAIL wheel_in_wait: state=%b dist=%0d want 11 and 4", state, dist_units);
        end
`endif
        step(0, 1, 0, 0, 0);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL pause_to_move: state=%b want 01", state);
        end
        step(0, 0, 0, 0, 0);
        $display("pause_toggle: state=%b move=%0d wait=%0d", state, move_sec, wait_sec);
    endtask

    task automatic test_stop_priority();
        step(1, 0, 1, 0, 0);
        total++;
        if (state !== 2'b00 || ride_done !== 1'b1) begin
            bad++; $display("FAIL stop_over_start: state=%b done=%b want 00 1", state, ride_done);
        end
        step(0, 0, 0, 1, 1);
        total++;
        if (ride_done !== 1'b0) begin
            bad++; $display("FAIL done_one_cycle: done=%b want 0", ride_done);
        end
        total++;
        if (move_sec !== 16'd3 || wait_sec !== 16'd2 || dist_units !== 16'd4) begin
            bad++; $display("FAIL idle_hold: move=%0d wait=%0d dist=%0d want 3 2 4", move_sec, wait_sec, dist_units);
        end
        step(1, 0, 0, 0, 0);
        total++;
        if (state !== 2'b01 || move_sec !== '0 || wait_sec !== '0 || dist_units !== '0) begin
            bad++; $display("FAIL restart_clear: state=%b move=%0d wait=%0d dist=%0d want 01 0 0 0",
                            state, move_sec, wait_sec, dist_units);
        end
        step(0, 0, 0, 0, 0);
        $display("stop_priority: state=%b done=%b", state, ride_done);
    endtask

    task automatic test_hold_start();
        int changes;
        logic [1:0] last;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        changes = 0;
        last = state;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0);
            if (state !== last) changes++;
            last = state;
        end
        total++;
        if (changes != 1 || state !== 2'b01) begin
            bad++; $display("FAIL hold_start: changes=%0d state=%b want 1 and 01", changes, state);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        total++;
        if (state !== 2'b11) begin
            bad++; $display("FAIL pause_after_hold: state=%b want 11", state);
        end
        $display("hold_start: changes=%0d state=%b", changes, state);
    endtask

    task automatic test_saturation();
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        // Wheel runs alongside every tick so the silence timer never expires.
        for (int i = 0; i < 65534; i++) step(0, 0, 0, 1, 1);
        total++;
        if (move_sec !== 16'hFFFE) begin
            bad++; $display("FAIL preload: move=%h want fffe", move_sec);
        end
        repeat (3) step(0, 0, 0, 1, 1);
        total++;
        if (move_sec !== 16'hFFFF || dist_units !== 16'hFFFF || state !== 2'b01) begin
            bad++; $display("FAIL saturate: move=%h dist=%h state=%b want ffff ffff 01", move_sec, dist_units, state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 2'b00 || move_sec !== '0 || wait_sec !== '0 || dist_units !== '0 || ride_done !== 1'b0) begin
            bad++; $display("FAIL async_reset: state=%b move=%h wait=%h dist=%h done=%b want all zero",
                            state, move_sec, wait_sec, dist_units, ride_done);
        end
        btn_start = 0; btn_pause = 0; btn_stop = 0; tick_1hz = 0; wheel_pulse = 0;
        model_reset();
        $display("saturation: move=%h after async reset state=%b", move_sec, state);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef TAXI_AUTO_WAIT_EN
    task automatic test_auto_wait();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL auto_early: state=%b want 01", state);
        end
        step(0, 0, 0, 1, 0);
        total++;
        if (state !== 2'b11) begin
            bad++; $display("FAIL auto_timeout: state=%b want 11", state);
        end
        step(0, 0, 0, 0, 1);
        total++;
        if (state !== 2'b01 || dist_units !== 16'd1) begin
            bad++; $display("FAIL auto_resume: state=%b dist=%0d want 01 1", state, dist_units);
        end
        repeat (4) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL pulse_wins: state=%b want 01", state);
        end
        step(0, 0, 0, 1, 0);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL timer_cleared: state=%b want 01", state);
        end
        $display("auto_wait: state=%b dist=%0d move=%0d", state, dist_units, move_sec);
    endtask
`endif

    task automatic test_random();
        bit s, p, st;
        s = 0; p = 0; st = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) s  = !s;
            if ($urandom_range(0, 5) == 0) p  = !p;
            if ($urandom_range(0, 9) == 0) st = !st;
            step(s, p, st, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            total++;
            if (state !== ride_code(m_ride) || ride_done !== m_done || move_sec !== CNT_W'(m_move)
                || wait_sec !== CNT_W'(m_wait) || dist_units !== CNT_W'(m_dist)) begin
                bad++;
                $display("FAIL random[%0d]: state=%b done=%b move=%0d wait=%0d dist=%0d want %b %b %0d %0d %0d",
                         i, state, ride_done, move_sec, wait_sec, dist_units,
                         ride_code(m_ride), m_done, m_move, m_wait, m_dist);
            end
            $display("random[%0d]: btn=%b%b%b state=%b move=%0d wait=%0d dist=%0d done=%b",
                     i, st, p, s, state, move_sec, wait_sec, dist_units, ride_done);
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_pause_toggle();
        test_stop_priority();
        test_hold_start();
        test_saturation();
`ifdef TAXI_AUTO_WAIT_EN
        test_auto_wait();
`endif
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
